booth_mul_sched: RTL
====================

// Module: booth_mul_sched
// PURPOSE
//  Shares one 4-bit signed Booth multiplier core among NREQ requesters using round-robin arbitration.
//  Owns the core's start/X/Y inputs and holds the operands stable for the whole multiply.
//  Captures the core result on mul_valid and returns it to the granted requester with a done pulse.
//  A watchdog recovers the block if the core never signals valid.
// PARAMETERS
//  NREQ     4   number of requesters (2..8)
//  W        4   operand width; result width is 2*W
//  TIMEOUT  15  max cycles in WAIT before the watchdog aborts the job (must be > core latency)
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        asynchronous reset, active-low
//  req        in   NREQ     per-requester request level; held high until gnt
//  x_in       in   NREQ*W   operand X of requester i at bits [i*W +: W], signed
//  y_in       in   NREQ*W   operand Y of requester i at bits [i*W +: W], signed
//  gnt        out  NREQ     one-hot, one-cycle pulse: operands of requester i accepted
//  done       out  NREQ     one-hot, one-cycle pulse: z_out valid for requester i
//  z_out      out  2*W      signed product; holds its value until the next done
//  err        out  1        one-cycle pulse with done when the watchdog aborted the job
//  busy       out  1        high in every state except IDLE
//  mul_start  out  1        one-cycle start pulse to the core
//  mul_x      out  W        X operand to the core, stable from ISSUE until the job ends
//  mul_y      out  W        Y operand to the core, stable from ISSUE until the job ends
//  mul_valid  in   1        core result-valid pulse
//  mul_z      in   2*W      core product
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, rr_ptr=0, wdog=0.
//   All outputs are 0, including gnt, done, z_out, err, busy, mul_start, mul_x, mul_y.
//  FSM:
//   - IDLE -> ISSUE when |req=1.
//   - ISSUE -> WAIT unconditionally (one cycle).
//   - WAIT -> RESP on mul_valid, or when wdog==TIMEOUT.
//   - RESP -> IDLE unconditionally (one cycle).
//  IDLE:
//   - Winner = first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
//   - Latch owner=i; latch mul_x=x_in[i], mul_y=y_in[i].
//  ISSUE:
//   - gnt[owner]=1 and mul_start=1 for exactly this cycle.
//   - Clear wdog.
//  WAIT:
//   - wdog increments every cycle.
//   - On mul_valid: capture z_out<=mul_z.
//   - On wdog==TIMEOUT without mul_valid: z_out<=0, set abort flag.
//  RESP:
//   - done[owner]=1 for one cycle; err=abort flag.
//   - rr_ptr<=(owner+1) mod NREQ; clear abort flag.
//  Latency:
//   - req sampled high in IDLE at edge k: gnt and mul_start high in cycle k+1.
//   - mul_valid high at edge m: done high in cycle m+1.
//  Operands:
//   - Requester operands are sampled only at the arbitration edge.
//   - mul_x and mul_y never change while busy=1, because the core re-reads X each step.
//  Requests arriving while busy stay pending and are arbitrated on the next IDLE cycle.
//   A requester may drop req before gnt; a dropped request is not served.
//  Back-to-back jobs: RESP->IDLE->ISSUE, so at most one idle cycle between jobs.
//  A requester re-requesting right after done gets lowest priority (fairness).
//  mul_valid outside WAIT is ignored.
//   mul_valid in the same cycle the watchdog fires counts as valid: z_out=mul_z, err=0.
//  gnt and done are never asserted in the same cycle. At most one bit of each is set.
//  Arithmetic: z_out is a pass-through of the core's 2*W two's-complement product. No rescaling.
//  Reset mid-job: all state clears immediately. No done is issued for the aborted job.
//   The core shares rst, so it also restarts.
// TESTING
//  - Single request: req[0]=1, X=3, Y=-2 -> gnt[0] and mul_start together, mul_x=3, mul_y=-2,
//    then done[0] the cycle after mul_valid, z_out=8'hFA, err=0.
//  - All four requesting from reset, operands (i+1, 2) -> grants in order 0,1,2,3;
//    z_out 2,4,6,8 with matching done bits.
//  - Fairness: req[0] held permanently, req[2] raised during job 0 -> next grant goes to 2, then 0.
//  - Operand stability: change x_in/y_in every cycle during WAIT -> mul_x/mul_y constant;
//    result matches the values sampled at grant.
//  - Watchdog: core model that never asserts mul_valid -> done[owner] and err high
//    TIMEOUT+2 cycles after gnt, z_out=0, next request served normally.
//  - Reset mid-WAIT: drop rst -> all outputs 0 asynchronously, no done.
//    After release, req[1] is granted first (rr_ptr=0 and only req[1] active).

Source files
------------

// File: rtl/booth_mul_sched.sv
// Round-robin scheduler sharing one signed Booth multiplier core among NREQ requesters.
// Operands are latched at arbitration and held until the job ends; a watchdog aborts stalled jobs.
module booth_mul_sched #(
  parameter int NREQ    = 4,
  parameter int W       = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] x_in,
  input  logic [NREQ*W-1:0] y_in,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [2*W-1:0]    z_out,
  output logic              err,
  output logic              busy,
  output logic              mul_start,
  output logic [W-1:0]      mul_x,
  output logic [W-1:0]      mul_y,
  input  logic              mul_valid,
  input  logic [2*W-1:0]    mul_z
);

  localparam int PW  = $clog2(NREQ);
  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            r_state;
  logic [PW-1:0]     r_rr_ptr;
  logic [PW-1:0]     r_owner;
  logic [WDW-1:0]    r_wdog;
  logic [NREQ-1:0]   r_gnt;
  logic [NREQ-1:0]   r_done;
  logic [2*W-1:0]    r_z;
  logic              r_err;
  logic              r_busy;
  logic              r_start;
  logic [W-1:0]      r_x;
  logic [W-1:0]      r_y;

  logic [PW:0]       w_sum  [NREQ];
  logic [PW-1:0]     w_cand [NREQ];
  logic [W-1:0]      w_xs   [NREQ];
  logic [W-1:0]      w_ys   [NREQ];
  logic [PW-1:0]     w_win;
  logic              w_found;
  logic [PW-1:0]     w_next_ptr;

  // w_cand[k] is the requester index at search offset k from the round-robin pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_cand
      assign w_sum[gi]  = {1'b0, r_rr_ptr} + (PW+1)'(gi);
      assign w_cand[gi] = (w_sum[gi] >= (PW+1)'(NREQ)) ? PW'(w_sum[gi] - (PW+1)'(NREQ))
                                                      : w_sum[gi][PW-1:0];
      assign w_xs[gi]   = x_in[gi*W +: W];
      assign w_ys[gi]   = y_in[gi*W +: W];
    end
  endgenerate

  // Scan from the farthest offset down so the nearest active requester wins.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[w_cand[k]]) begin
        w_win   = w_cand[k];
        w_found = 1'b1;
      end
    end
  end

  assign w_next_ptr = (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + PW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_owner  <= '0;
      r_wdog   <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_z      <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_start  <= 1'b0;
      r_x      <= '0;
      r_y      <= '0;
    end else begin
      r_gnt   <= '0;
      r_start <= 1'b0;
      r_done  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_win;
            r_x     <= w_xs[w_win];
            r_y     <= w_ys[w_win];
            r_gnt   <= NREQ'(1) << w_win;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_wdog  <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          r_wdog <= r_wdog + WDW'(1);
          // A valid arriving on the watchdog cycle still wins over the abort.
          if (mul_valid) begin
            r_z     <= mul_z;
            r_err   <= 1'b0;
            r_done  <= NREQ'(1) << r_owner;
            r_state <= S_RESP;
          end else if (r_wdog == WDW'(TIMEOUT)) begin
            r_z     <= '0;
            r_err   <= 1'b1;
            r_done  <= NREQ'(1) << r_owner;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_rr_ptr <= w_next_ptr;
          r_err    <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign done      = r_done;
  assign z_out     = r_z;
  assign err       = r_err;
  assign busy      = r_busy;
  assign mul_start = r_start;
  assign mul_x     = r_x;
  assign mul_y     = r_y;

endmodule
